// File: rtl/cu_tile_scheduler_pkg.sv
// Shared types for the computing-unit tile scheduler: FSM states and
// the result-tracker entry that rides alongside each activation pop.
package cu_tile_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } cu_sched_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } trk_entry_t;

endpackage

// File: rtl/cu_pipe_tracker.sv
// Shift register of tracker entries mirroring the datapath pipeline;
// the head entry tells whether the datapath output is a real (or final) result.
module cu_pipe_tracker
  import cu_tile_scheduler_pkg::*;
#(
  parameter int DEPTH = 36
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  trk_entry_t din,
  output trk_entry_t dout,
  output logic       empty
);

  trk_entry_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (clr) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout  = pipe[DEPTH-1];
  assign empty = (pipe == '0);

endmodule

// File: rtl/cu_tile_scheduler.sv
// Read-side sequencer of the computing unit: loads weight rows, streams
// activation/offset vectors in lockstep and tracks results through the datapath.
module cu_tile_scheduler
  import cu_tile_scheduler_pkg::*;
#(
  parameter int ACT_COUNT    = 16,
  parameter int MAX_VECTORS  = 256,
  // Default 36: queue read latency plus systolic array, accumulator and offset add stages.
  parameter int PIPE_LATENCY = 36,
  parameter int VCW          = $clog2(MAX_VECTORS + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           queue_busy_i,
  input  logic           start_i,
  input  logic           reuse_w_i,
  input  logic [VCW-1:0] vec_count_i,
  input  logic           abort_i,
  input  logic           weight_empty_i,
  input  logic           act_empty_i,
  input  logic           offset_empty_i,
  output logic           start_ready_o,
  output logic           weight_rd_en_o,
  output logic           weight_update_o,
  output logic           act_rd_en_o,
  output logic           offset_rd_en_o,
  output logic           result_valid_o,
  output logic           tile_done_o,
  output logic           busy_o
);

  localparam int WCW = $clog2(ACT_COUNT + 1);

  cu_sched_state_t state, state_nxt;
  logic [WCW-1:0]  w_ctr, w_ctr_nxt;
  logic [VCW-1:0]  v_ctr, v_ctr_nxt, vec_len, vec_len_nxt, vec_len_sat;
  logic            done_pend, done_nxt;
  logic            w_pop, a_pop, is_last, trk_clr, trk_empty;
  trk_entry_t      trk_in, trk_out;

  assign vec_len_sat = (vec_count_i > VCW'(MAX_VECTORS)) ? VCW'(MAX_VECTORS) : vec_count_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      w_ctr     <= '0;
      v_ctr     <= '0;
      vec_len   <= '0;
      done_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      w_ctr     <= w_ctr_nxt;
      v_ctr     <= v_ctr_nxt;
      vec_len   <= vec_len_nxt;
      done_pend <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    w_ctr_nxt   = w_ctr;
    v_ctr_nxt   = v_ctr;
    vec_len_nxt = vec_len;
    done_nxt    = 1'b0;
    w_pop       = 1'b0;
    a_pop       = 1'b0;
    is_last     = 1'b0;
    trk_clr     = 1'b0;
    trk_in      = '0;
    case (state)
      IDLE: begin
        if (start_i && start_ready_o) begin
          vec_len_nxt = vec_len_sat;
          w_ctr_nxt   = '0;
          v_ctr_nxt   = '0;
          if (!reuse_w_i)           state_nxt = LOAD_W;
          else if (vec_len_sat != '0) state_nxt = STREAM;
          else                      done_nxt  = 1'b1;
        end
      end
      LOAD_W: begin
        w_pop = ~weight_empty_i & ~queue_busy_i;
        if (w_pop) begin
          w_ctr_nxt = w_ctr + WCW'(1);
          if (w_ctr == WCW'(ACT_COUNT - 1)) begin
            if (vec_len == '0) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = STREAM;
            end
          end
        end
      end
      STREAM: begin
        // Activations and offsets share one enable so they cannot drift apart.
        a_pop = ~act_empty_i & ~offset_empty_i & ~queue_busy_i;
        if (a_pop) begin
          is_last      = (v_ctr == vec_len - VCW'(1));
          v_ctr_nxt    = v_ctr + VCW'(1);
          trk_in.valid = 1'b1;
          trk_in.last  = is_last;
          if (is_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (trk_empty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_i) begin
      state_nxt = IDLE;
      w_ctr_nxt = '0;
      v_ctr_nxt = '0;
      done_nxt  = 1'b0;
      w_pop     = 1'b0;
      a_pop     = 1'b0;
      trk_clr   = 1'b1;
      trk_in    = '0;
    end
  end

  cu_pipe_tracker #(.DEPTH(PIPE_LATENCY)) u_tracker (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (trk_clr),
    .din   (trk_in),
    .dout  (trk_out),
    .empty (trk_empty)
  );

  assign busy_o          = (state != IDLE) | ~trk_empty;
  assign start_ready_o   = (state == IDLE) & ~busy_o & ~queue_busy_i;
  assign weight_rd_en_o  = w_pop;
  assign weight_update_o = w_pop;
  assign act_rd_en_o     = a_pop;
  assign offset_rd_en_o  = a_pop;
  assign result_valid_o  = trk_out.valid;
  // Zero-length tiles finish from done_pend; streamed tiles from the tracker head.
  assign tile_done_o     = (trk_out.last | done_pend) & ~abort_i;

endmodule

// File: tb/tb_cu_tile_scheduler.sv
// Self-checking bench for cu_tile_scheduler: table-driven tiles, randomized
// tiles against a pop-count/delay-line model, and hand sequences for abort/reset/busy.
module tb_cu_tile_scheduler;

  localparam int AC  = 4;
  localparam int LAT = 6;
  localparam int MV  = 8;
  localparam int VW  = $clog2(MV + 1);

  logic          clk = 1'b0;
  logic          rst_ni, queue_busy_i, start_i, reuse_w_i, abort_i;
  logic [VW-1:0] vec_count_i;
  logic          weight_empty_i, act_empty_i, offset_empty_i;
  logic          start_ready_o, weight_rd_en_o, weight_update_o, act_rd_en_o;
  logic          offset_rd_en_o, result_valid_o, tile_done_o, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cu_tile_scheduler #(.ACT_COUNT(AC), .MAX_VECTORS(MV), .PIPE_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .queue_busy_i(queue_busy_i), .start_i(start_i),
    .reuse_w_i(reuse_w_i), .vec_count_i(vec_count_i), .abort_i(abort_i),
    .weight_empty_i(weight_empty_i), .act_empty_i(act_empty_i), .offset_empty_i(offset_empty_i),
    .start_ready_o(start_ready_o), .weight_rd_en_o(weight_rd_en_o), .weight_update_o(weight_update_o),
    .act_rd_en_o(act_rd_en_o), .offset_rd_en_o(offset_rd_en_o), .result_valid_o(result_valid_o),
    .tile_done_o(tile_done_o), .busy_o(busy_o)
  );

  typedef struct {
    int vc;
    bit reuse;
    int mode;   // 0: queues full, 1: act_empty toggles each cycle, 2: random empties
    int exp_w;  // weight pops required
    int exp_v;  // activation pops required
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (start_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, "_ready_timeout"}, start_ready_o, 1);
  endtask

  task automatic drive_empties(input int mode, input int c);
    weight_empty_i = 1'b0; act_empty_i = 1'b0; offset_empty_i = 1'b0;
    if (mode == 1) act_empty_i = c[0];
    else if (mode == 2) begin
      weight_empty_i = ($urandom_range(0, 99) < 30);
      act_empty_i    = ($urandom_range(0, 99) < 30);
      offset_empty_i = ($urandom_range(0, 99) < 20);
    end
  endtask

  // Model: pops follow queue availability until the required counts are met,
  // weights first; results appear LAT cycles after each activation pop.
  task automatic run_tile(input vec_t v, input string nm);
    bit pop_hist [0:511];
    int wp = 0, ap = 0, dw = 0, da = 0, done_c = -1, c = 0;
    bit exp_we, exp_ae, exp_rv;
    wait_ready(nm);
    @(negedge clk);
    start_i = 1'b1; vec_count_i = VW'(v.vc); reuse_w_i = v.reuse;
    drive_empties(v.mode, 0);
    #1 chk({nm, "_start_ready"}, start_ready_o, 1);
    pop_hist[0] = 1'b0;
    if (v.exp_w == 0 && v.exp_v == 0) done_c = 1;
    while (c < 400) begin
      c++;
      @(negedge clk);
      start_i = 1'b0;
      drive_empties(v.mode, c);
      #1;
      exp_we = (wp < v.exp_w) ? ~weight_empty_i : 1'b0;
      exp_ae = (wp >= v.exp_w && ap < v.exp_v) ? (~act_empty_i & ~offset_empty_i) : 1'b0;
      exp_rv = (c >= LAT) ? pop_hist[c-LAT] : 1'b0;
      chk({nm, "_weight_rd_en"}, weight_rd_en_o, exp_we);
      chk({nm, "_weight_update"}, weight_update_o, exp_we);
      chk({nm, "_act_rd_en"}, act_rd_en_o, exp_ae);
      chk({nm, "_offset_rd_en"}, offset_rd_en_o, exp_ae);
      chk({nm, "_result_valid"}, result_valid_o, exp_rv);
      chk({nm, "_tile_done"}, tile_done_o, (c == done_c));
      pop_hist[c] = exp_ae;
      dw += int'(weight_rd_en_o);
      da += int'(act_rd_en_o);
      if (exp_we) begin
        wp++;
        if (wp == v.exp_w && v.exp_v == 0) done_c = c + 1;
      end
      if (exp_ae) begin
        ap++;
        if (ap == v.exp_v) done_c = c + LAT;
      end
      if (done_c >= 0 && c == done_c + 2) break;
    end
    chk({nm, "_finished_in_bound"}, (c < 400), 1);
    chk({nm, "_weight_pops"}, dw, v.exp_w);
    chk({nm, "_act_pops"}, da, v.exp_v);
    chk({nm, "_idle_busy"}, busy_o, 0);
    chk({nm, "_idle_ready"}, start_ready_o, 1);
  endtask

  initial begin
    vec_t tbl [7];
    vec_t rv;
    int   dones, vals;

    rst_ni = 1'b0; queue_busy_i = 1'b1; start_i = 1'b0; reuse_w_i = 1'b0;
    vec_count_i = '0; abort_i = 1'b0;
    weight_empty_i = 1'b1; act_empty_i = 1'b1; offset_empty_i = 1'b1;
    #12;
    chk("rst_ready_qbusy", start_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_tile_done", tile_done_o, 0);
    chk("rst_rd_en", {weight_rd_en_o, weight_update_o, act_rd_en_o, offset_rd_en_o}, 0);
    queue_busy_i = 1'b0;
    #1 chk("rst_ready_follows_qbusy", start_ready_o, 1);
    @(negedge clk); rst_ni = 1'b1;

    tbl[0] = '{vc: 3,  reuse: 0, mode: 0, exp_w: 4, exp_v: 3};  // basic tile
    tbl[1] = '{vc: 4,  reuse: 0, mode: 1, exp_w: 4, exp_v: 4};  // act_empty toggling
    tbl[2] = '{vc: 2,  reuse: 0, mode: 0, exp_w: 4, exp_v: 2};  // tile A
    tbl[3] = '{vc: 5,  reuse: 1, mode: 0, exp_w: 0, exp_v: 5};  // weight reuse
    tbl[4] = '{vc: 0,  reuse: 0, mode: 0, exp_w: 4, exp_v: 0};  // weight-only
    tbl[5] = '{vc: 12, reuse: 1, mode: 0, exp_w: 0, exp_v: 8};  // saturation
    tbl[6] = '{vc: 0,  reuse: 1, mode: 0, exp_w: 0, exp_v: 0};  // empty reuse tile
    for (int i = 0; i < 7; i++) run_tile(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      rv.vc    = $urandom_range(0, 12);
      rv.reuse = $urandom_range(0, 1);
      rv.mode  = 2;
      rv.exp_w = rv.reuse ? 0 : AC;
      rv.exp_v = (rv.vc > MV) ? MV : rv.vc;
      run_tile(rv, $sformatf("rnd%0d", i));
    end

    // Abort on the second activation pop.
    wait_ready("abort");
    @(negedge clk); start_i = 1'b1; vec_count_i = 4; reuse_w_i = 1'b0; drive_empties(0, 0);
    @(negedge clk); start_i = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("abort_first_pop", act_rd_en_o, 1);
    @(negedge clk); abort_i = 1'b1;
    #1 chk("abort_same_cycle_rd_en", act_rd_en_o | offset_rd_en_o, 0);
    chk("abort_no_done", tile_done_o, 0);
    @(negedge clk); abort_i = 1'b0;
    #1 chk("abort_next_rd_en", act_rd_en_o | offset_rd_en_o | weight_rd_en_o, 0);
    chk("abort_busy_cleared", busy_o, 0);
    dones = 0; vals = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      dones += int'(tile_done_o);
      vals  += int'(result_valid_o);
    end
    chk("abort_flushed_valid", vals, 0);
    chk("abort_no_tile_done", dones, 0);

    // Asynchronous reset mid-DRAIN.
    wait_ready("rst_mid");
    @(negedge clk); start_i = 1'b1; vec_count_i = 1; reuse_w_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    #1 chk("rstmid_pop", act_rd_en_o, 1);
    @(negedge clk); @(negedge clk);
    #1 chk("rstmid_busy_before", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk("rstmid_busy", busy_o, 0);
    chk("rstmid_outs", {weight_rd_en_o, weight_update_o, act_rd_en_o, offset_rd_en_o,
                        result_valid_o, tile_done_o}, 0);
    chk("rstmid_ready", start_ready_o, 1);
    @(negedge clk); rst_ni = 1'b1;
    vals = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      vals += int'(result_valid_o) + int'(tile_done_o);
    end
    chk("rstmid_no_results", vals, 0);

    // queue_busy: ignored start, then a stall in LOAD_W.
    @(negedge clk); queue_busy_i = 1'b1; start_i = 1'b1; vec_count_i = 1; reuse_w_i = 1'b0;
    #1 chk("qbusy_not_ready", start_ready_o, 0);
    @(negedge clk); start_i = 1'b0;
    #1 chk("qbusy_start_ignored", busy_o, 0);
    @(negedge clk); queue_busy_i = 1'b0;
    #1 chk("qbusy_no_weight_pop", weight_rd_en_o, 0);
    chk("qbusy_ready_again", start_ready_o, 1);
    @(negedge clk); start_i = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk); start_i = 1'b0;
      queue_busy_i = (c >= 3 && c <= 5);
      #1;
      chk($sformatf("qbusy_w_c%0d", c), weight_rd_en_o, (c <= 2 || c == 6 || c == 7));
      chk($sformatf("qbusy_a_c%0d", c), act_rd_en_o, (c == 8));
      chk($sformatf("qbusy_done_c%0d", c), tile_done_o, (c == 14));
      if (c >= 3 && c <= 5) chk($sformatf("qbusy_busy_c%0d", c), busy_o, 1);
    end
    wait_ready("qbusy_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
